// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and sequencing controller for a classic 5-stage pipeline.
//             Detects data hazards, stalls IF/ID, and bubbles ID control bits.
//             Flushes IF/ID on a taken branch.
//             Drains the back end before halting.
//             Optionally drives ALU operand forwarding selects.
//  Build    : define PIPE_FWD_EN to build in forwarding.
//             With forwarding, only load-use stalls.
//             Without it, any EX/MEM producer stalls and forward_a/b are 00.
//  Ports    : clk, startin_n (async active-low reset)
//             if_id_rs/rt, if_id_uses_rt     - ID source registers
//             id_ex_rs/rt                    - EX source registers
//             id_ex_rd/ex_mem_rd/mem_wb_rd   - stage destinations
//             *_reg_write, id_ex_mem_read    - stage control bits
//             branch_taken, halt_id          - control-flow events
//             pc_write, if_id_write          - pipeline enables
//             if_id_flush, ctrl_bubble       - pipeline squash
//             forward_a/b                    - operand selects
//             running, halted                - status
//             stall_count                    - saturating stall counter
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       startin_n,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       if_id_uses_rt,
    input  logic [4:0] id_ex_rs,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] id_ex_rd,
    input  logic [4:0] ex_mem_rd,
    input  logic [4:0] mem_wb_rd,
    input  logic       id_ex_reg_write,
    input  logic       ex_mem_reg_write,
    input  logic       mem_wb_reg_write,
    input  logic       id_ex_mem_read,
    input  logic       branch_taken,
    input  logic       halt_id,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       ctrl_bubble,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       running,
    output logic       halted,
    output logic [7:0] stall_count
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_run   = 3'd1;
    localparam logic [2:0] c_stall = 3'd2;
    localparam logic [2:0] c_drain = 3'd3;
    localparam logic [2:0] c_halt  = 3'd4;

    // Last DRAIN cycle index: cycles 0,1,2 let EX, MEM and WB empty.
    localparam logic [1:0] c_drain_last = 2'd2;

    logic [2:0] r_state;
    logic [1:0] r_drain;
    logic [7:0] r_stall_count;

    logic [2:0] w_next;
    logic [1:0] w_drain_next;
    logic       w_stall;
    logic       w_hazard;
    logic       w_pc_write;
    logic       w_if_id_write;
    logic       w_if_id_flush;
    logic       w_ctrl_bubble;

    // Register 0 is hardwired; a producer only counts if it actually writes.
    function automatic logic f_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] src);
        return we && (rd != 5'd0) && (rd == src);
    endfunction

`ifdef PIPE_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = 1'b0;

    // Forwarding covers every ALU producer; only a load in EX cannot be
    // forwarded in time for the dependent instruction in ID.
    assign w_hazard = id_ex_mem_read &&
                      (f_match(id_ex_rd, id_ex_reg_write, if_id_rs) ||
                       (if_id_uses_rt && f_match(id_ex_rd, id_ex_reg_write, if_id_rt)));

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    // Selects are held at 00 in IDLE, which also covers the reset period.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (r_state != c_idle) begin
            if (f_match(ex_mem_rd, ex_mem_reg_write, id_ex_rs))
                forward_a = 2'b10;
            else if (f_match(mem_wb_rd, mem_wb_reg_write, id_ex_rs))
                forward_a = 2'b01;
            if (f_match(ex_mem_rd, ex_mem_reg_write, id_ex_rt))
                forward_b = 2'b10;
            else if (f_match(mem_wb_rd, mem_wb_reg_write, id_ex_rt))
                forward_b = 2'b01;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{id_ex_rs, id_ex_rt, mem_wb_rd, mem_wb_reg_write,
                            id_ex_mem_read};

    // Without forwarding, wait until the producer reaches WB.  The register
    // file writes before it reads, so a MEM/WB producer never stalls.
    assign w_hazard = f_match(id_ex_rd, id_ex_reg_write, if_id_rs) ||
                      f_match(ex_mem_rd, ex_mem_reg_write, if_id_rs) ||
                      (if_id_uses_rt &&
                       (f_match(id_ex_rd, id_ex_reg_write, if_id_rt) ||
                        f_match(ex_mem_rd, ex_mem_reg_write, if_id_rt)));

    assign forward_a = 2'b00;
    assign forward_b = 2'b00;
`endif

    // Enables must react in the same cycle as the hazard, so they are decoded
    // from the registered state and the current stage information.
    always_comb begin
        w_next        = r_state;
        w_drain_next  = r_drain;
        w_stall       = 1'b0;
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_if_id_flush = 1'b0;
        w_ctrl_bubble = 1'b1;
        case (r_state)
            c_idle: begin
                w_next = c_run;
            end
            c_run, c_stall: begin
                if (branch_taken) begin
                    // Redirect wins over a stall; the stalled ID instruction
                    // is on the wrong path anyway.
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_next        = c_run;
                end else if (w_hazard) begin
                    w_stall = 1'b1;
                    w_next  = c_stall;
                end else if (halt_id) begin
                    w_next       = c_drain;
                    w_drain_next = 2'd0;
                end else begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_ctrl_bubble = 1'b0;
                    w_next        = c_run;
                end
            end
            c_drain: begin
                // Only the branch right behind the halt can still redirect.
                if (branch_taken && (r_drain == 2'd0)) begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_next        = c_run;
                end else if (r_drain == c_drain_last) begin
                    w_next = c_halt;
                end else begin
                    w_drain_next = r_drain + 2'd1;
                end
            end
            c_halt: begin
                w_next = c_halt;
            end
            default: begin
                w_next = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge startin_n) begin
        if (!startin_n) begin
            r_state       <= c_idle;
            r_drain       <= 2'd0;
            r_stall_count <= 8'd0;
        end else begin
            r_state <= w_next;
            r_drain <= w_drain_next;
            if (w_stall && (r_stall_count != 8'hFF))
                r_stall_count <= r_stall_count + 8'd1;
        end
    end

    assign pc_write    = w_pc_write;
    assign if_id_write = w_if_id_write;
    assign if_id_flush = w_if_id_flush;
    assign ctrl_bubble = w_ctrl_bubble;
    assign running     = (r_state == c_run) || (r_state == c_stall);
    assign halted      = (r_state == c_halt);
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
